// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length,
// default timing constants and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_e;

    // data[7:0], parity, stop
    localparam int FRAME_BITS = 10;

    localparam int INHIBIT_CYCLES_DEF = 5000;
    localparam int TIMEOUT_CYCLES_DEF = 750000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 3-flop synchroniser and falling-edge detect for PS/2 clk/data.
// Ports: clk, rst (sync, active-low), line_clk/line_data in;
//        clk_s/data_s synchronised levels, clk_fall/data_fall pulses.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_clk,
    input  logic line_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall,
    output logic data_fall
);

    logic [2:0] clk_sync_q, clk_sync_d;
    logic [2:0] data_sync_q, data_sync_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], line_clk};
        data_sync_d = {data_sync_q[1:0], line_data};
    end

    // Reset to the idle (high) level so no false fall follows reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign clk_s     = clk_sync_q[1];
    assign data_s    = data_sync_q[1];
    assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_fall = data_sync_q[2] & ~data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over
// open-drain ps2_clk/ps2_data (oe=1 pulls the line low).
// Ports: clk, rst (sync, active-low), ps2_clk/ps2_data sensed,
//        ps2_clk_oe/ps2_data_oe drives, tx_data/tx_valid/tx_ready,
//        busy, done and error pulses.
// Macro PS2_HOST_TX_TIMEOUT_EN builds the request-to-ack watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          data_oe_q, data_oe_d;
    logic          tx_ready_q, tx_ready_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic clk_s, data_s, clk_fall;
    logic unused_data_fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .line_clk  (ps2_clk),
        .line_data (ps2_data),
        .clk_s     (clk_s),
        .data_s    (data_s),
        .clk_fall  (clk_fall),
        .data_fall (unused_data_fall)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        timer_d   = timer_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shreg_d = {1'b1, odd_parity(tx_data), tx_data};
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[cnt_q];
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (data_s) begin
                        error_d   = 1'b1;
                        data_oe_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog overrides any transition taken this cycle.
        if (state_q inside {REQ, SHIFT, ACK, WAIT_IDLE}) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                error_d   = 1'b1;
                state_d   = IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
`endif

        tx_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            timer_q    <= '0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            timer_q    <= timer_d;
            data_oe_q  <= data_oe_d;
            tx_ready_q <= tx_ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model and a
// scoreboard of expected frame bits sampled on device clock rises.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int exp_done = 0;
    int exp_errs = 0;
    logic exp_q[$];

    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d);
        int w;
        w = 0;
        while (!tx_ready && w < 100) begin
            tick();
            w++;
        end
        check("accept_ready", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(~^d);
        exp_q.push_back(1'b1);
    endtask

    // Returns in the first cycle the start bit is driven (REQ).
    task automatic wait_req();
        int w;
        w = 0;
        while (!ps2_data_oe && w < INH + 50) begin
            tick();
            w++;
        end
        check("req_data_oe", ps2_data_oe, 1);
        check("req_clk_oe", ps2_clk_oe, 1);
    endtask

    task automatic dev_clock(input int nfalls, input bit ack);
        int   w;
        logic e;
        w = 0;
        while (ps2_clk_oe && w < 10) begin
            tick();
            w++;
        end
        check("clk_release", ps2_clk_oe, 0);
        check("start_bit", ps2_data, 0);
        tick(2);
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11 && ack) begin
                dev_data = 1'b0;
                tick(3);
            end
            dev_clk = 1'b0;
            tick(HALF);
            dev_clk = 1'b1;
            if (i <= 10) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("bit%0d", i), ps2_data, e);
                end
            end
            tick(HALF);
            if (i == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 60) begin
            tick();
            w++;
        end
        check("done_seen", done, 1);
        check("done_no_err", error, 0);
        tick();
        check("done_pulse", done, 0);
        check("ready_after", tx_ready, 1);
        exp_done++;
    endtask

    task automatic full_frame(input logic [7:0] d);
        accept(d);
        wait_req();
        dev_clock(11, 1'b1);
        wait_done();
    endtask

    initial begin
        logic [7:0] pats[3];
        int         w;
        int         n;
        pats = '{8'h01, 8'h00, 8'hFF};

        rst = 1'b0;
        tick(3);
        check("rst_ready", tx_ready, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 1'b1;
        tick();
        check("ready_after_rst", tx_ready, 1);

        full_frame(8'hED);
        check("ed_done_cnt", done_cnt, exp_done);
        check("ed_err_cnt", err_cnt, exp_errs);

        for (int k = 0; k < 3; k++) full_frame(pats[k]);

        accept(8'hF4);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        tick(3);
        check("busy_ready", tx_ready, 0);
        check("busy_busy", busy, 1);
        wait_req();
        tx_valid = 1'b0;
        dev_clock(11, 1'b1);
        wait_done();
        tick(5);
        check("no_queue_busy", busy, 0);
        check("sb_drained", exp_q.size(), 0);

        accept(8'h55);
        wait_req();
        dev_clock(10, 1'b0);
        dev_clk = 1'b0;
        w = 0;
        while (!error && w < 20) begin
            tick();
            w++;
        end
        check("nack_error", error, 1);
        check("nack_done", done, 0);
        check("nack_clk_oe", ps2_clk_oe, 0);
        check("nack_data_oe", ps2_data_oe, 0);
        tick();
        check("nack_pulse", error, 0);
        check("nack_ready", tx_ready, 1);
        dev_clk = 1'b1;
        tick(HALF);
        exp_errs++;
        check("nack_err_cnt", err_cnt, exp_errs);

        accept(8'hA5);
        wait_req();
        exp_q.delete();
`ifdef PS2_HOST_TX_TIMEOUT_EN
        n = 0;
        while (!error && n < 2 * TMO) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_clk_oe", ps2_clk_oe, 0);
        check("timeout_data_oe", ps2_data_oe, 0);
        exp_errs++;
        tick();
        check("timeout_ready", tx_ready, 1);
`else
        n = 0;
        tick(300);
        check("no_timeout_busy", busy, 1);
        check("no_timeout_err", error, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif
        check("to_err_cnt", err_cnt, exp_errs);

        accept(8'h00);
        wait_req();
        dev_clock(4, 1'b1);
        check("mid_data_oe", ps2_data_oe, 1);
        rst = 1'b0;
        tick();
        check("rst_mid_clk_oe", ps2_clk_oe, 0);
        check("rst_mid_data_oe", ps2_data_oe, 0);
        check("rst_mid_busy", busy, 0);
        rst = 1'b1;
        exp_q.delete();
        tick(2);
        check("rst_mid_done", done_cnt, exp_done);
        check("rst_mid_err", err_cnt, exp_errs);

        full_frame(8'hED);
        check("final_done_cnt", done_cnt, exp_done);
        check("final_err_cnt", err_cnt, exp_errs);
        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using open-drain clock/data.
- Pairs with the existing PS/2 receive path and shares the same physical ps2_clk/ps2_data lines.
- Asserts busy while it owns the bus, so the receive path discards frames during a host transfer.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles to hold ps2_clk low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles from request to ack before abort (15 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- ps2_clk  input  1  sensed PS/2 clock line (asynchronous)
- ps2_data  input  1  sensed PS/2 data line (asynchronous)
- ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release
- ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release
- tx_data  input  8  command byte
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  1 in IDLE; tx_data is accepted when tx_valid&tx_ready
- busy  output  1  1 in every state except IDLE
- done  output  1  one-cycle pulse: device acked the byte
- error  output  1  one-cycle pulse: no ack (data high at ack sample) or timeout

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0 during reset and 1 in the first cycle after, busy=0, done=0, error=0. State=IDLE, bit counter=0, timer=0.
- Synchronisers and edge detection:
  - ps2_clk and ps2_data each pass through a 3-flop synchroniser.
  - fall = sync[2]&~sync[1]; ack and line-idle checks use the synchronised data.
- Parity: odd parity is latched at accept as ~^tx_data. The shift register is loaded with {1'b1 stop, parity, tx_data}.
- FSM:
  - IDLE: tx_ready=1. On tx_valid, latch the frame, clear the timer, go to INHIBIT.
  - INHIBIT: clk_oe=1. After INHIBIT_CYCLES cycles, set data_oe=1 (start bit) and go to REQ.
  - REQ: clk_oe=1, data_oe=1 for exactly one cycle. Then clk_oe=0 (release clock), go to SHIFT with count=0.
  - SHIFT: on each fall, present shreg[count] (data_oe = ~bit) and increment count.
    - count 0..7 are data bits LSB first, 8 is parity, 9 is stop (released).
    - After the 10th fall go to ACK.
  - ACK: on the next fall, sample data. Low goes to WAIT_IDLE; high pulses error and goes to IDLE.
  - WAIT_IDLE: when synchronised clk and data are both high, pulse done and go to IDLE.
- Timing:
  - The timer runs from entry into REQ through WAIT_IDLE.
  - Each changed data_oe appears the cycle after fall is detected, i.e. 3–4 clk after the pin edge.
- Boundaries:
  - tx_valid outside IDLE is ignored (tx_ready=0). There is no queueing.
  - rst low mid-frame releases both lines immediately (next edge) and returns to IDLE. No done/error pulse.
  - done and error are never both asserted in the same cycle.
  - Falls seen in IDLE or INHIBIT are ignored.

Optional Feature:
- Macro PS2_HOST_TX_TIMEOUT_EN.
  - Defined: the watchdog is active. When the timer reaches TIMEOUT_CYCLES in REQ/SHIFT/ACK/WAIT_IDLE, both lines are released, error pulses, and the FSM goes to IDLE.
  - Not defined: no timer logic is built and the FSM waits indefinitely for device clocks. error pulses only on a missing ack.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE)
  - frame length constant 10
  - default cycle constants
  - parity helper function
- Sub-module ps2_line_sync: 3-flop synchroniser plus falling-edge detect for clk and data. It is natural to reuse on the receive side.

Test Plan:
- tx_data=0xED with the device model acking → bits presented on falls 1–8 = 1,0,1,1,0,1,1,1; parity=1; stop released. One done pulse, error never asserted.
- tx_data=0x01 → parity bit 0. tx_data=0x00 → parity 1. tx_data=0xFF → parity 1. Each is checked on fall 9.
- Accept 0xF4 and assert tx_valid again while busy → second request ignored, tx_ready=0 until done, only 0xF4 sent.
- Device leaves data high on fall 11 → error pulse for 1 cycle, both oe=0, tx_ready=1 next cycle.
- Device never clocks, with PS2_HOST_TX_TIMEOUT_EN and TIMEOUT_CYCLES=200 → error exactly 200 cycles after REQ entry. Without the macro → busy stays 1.
- rst=0 asserted during SHIFT count=4 → next cycle clk_oe=0, data_oe=0, busy=0. A fresh 0xED after reset is sent correctly.
